// File: rtl/vga_ctrl_pkg.sv
// Shared types and helpers for the frame-synchronous VGA control blocks:
// pattern codes, request/state encodings and wrap-around pattern stepping.
package vga_ctrl_pkg;

    localparam int PATTERN_WIDTH = 4;

    typedef logic [PATTERN_WIDTH-1:0] pattern_t;

    localparam pattern_t PAT_BLACK      = 4'd0;
    localparam pattern_t PAT_WHITE      = 4'd1;
    localparam pattern_t PAT_COLOR_BARS = 4'd5;
    localparam pattern_t PAT_CHECKER    = 4'd6;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_NEXT,
        REQ_PREV,
        REQ_LOAD
    } req_kind_e;

    typedef enum logic {
        IDLE,
        AUTO
    } state_e;

    typedef struct packed {
        req_kind_e kind;
        pattern_t  code;
    } request_t;

    function automatic logic pattern_in_range(pattern_t code, pattern_t first, pattern_t last);
        return (code >= first) && (code <= last);
    endfunction

    // With first == last both helpers return the current code unchanged.
    function automatic pattern_t pattern_next(pattern_t cur, pattern_t first, pattern_t last);
        if (cur == last) return first;
        return cur + pattern_t'(1);
    endfunction

    function automatic pattern_t pattern_prev(pattern_t cur, pattern_t first, pattern_t last);
        if (cur == first) return last;
        return cur - pattern_t'(1);
    endfunction

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Control/status bundle between a pattern-sequencer client (master) and the
// sequencer itself (slave).
interface vga_pattern_sequencer_if #(
    parameter int FRAME_CNT_WIDTH = 8
);
    import vga_ctrl_pkg::*;

    logic                       i_VSync;
    logic                       i_Auto_En;
    logic                       i_Next;
    logic                       i_Prev;
    logic                       i_Load;
    pattern_t                   i_Load_Pattern;
    pattern_t                   o_Pattern;
    logic                       o_Frame_Pulse;
    logic [FRAME_CNT_WIDTH-1:0] o_Frame_Count;
    logic                       o_Load_Err;
    logic                       o_Pending;

    modport master (
        output i_VSync, i_Auto_En, i_Next, i_Prev, i_Load, i_Load_Pattern,
        input  o_Pattern, o_Frame_Pulse, o_Frame_Count, o_Load_Err, o_Pending
    );

    modport slave (
        input  i_VSync, i_Auto_En, i_Next, i_Prev, i_Load, i_Load_Pattern,
        output o_Pattern, o_Frame_Pulse, o_Frame_Count, o_Load_Err, o_Pending
    );

endinterface

// File: rtl/vga_frame_edge_detect.sv
// Registers VSync and strobes o_Boundary for the one cycle in which VSync falls
// (start of vertical blanking). Reset low, so no edge is seen until VSync was high.
module vga_frame_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_VSync,
    output logic o_Boundary
);

    logic vsync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) vsync_q <= 1'b0;
        else          vsync_q <= i_VSync;
    end

    assign o_Boundary = vsync_q & ~i_VSync;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Selects the test pattern; manual, load and auto-cycle changes are all deferred
// to the VSync falling edge so a frame is never torn.
module vga_pattern_sequencer
    import vga_ctrl_pkg::*;
#(
    parameter int PATTERN_FIRST      = 0,
    parameter int PATTERN_LAST       = 7,
    parameter int RESET_PATTERN      = 5,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int FRAME_CNT_WIDTH    = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    vga_pattern_sequencer_if.slave bus
);

    localparam pattern_t FIRST_C = pattern_t'(PATTERN_FIRST);
    localparam pattern_t LAST_C  = pattern_t'(PATTERN_LAST);
    localparam pattern_t RESET_C = pattern_t'(RESET_PATTERN);
    localparam int       AUTO_W  = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(FRAMES_PER_PATTERN - 1);

    logic                       boundary;
    logic                       load_ok;
    state_e                     state_q, state_d;
    request_t                   pend_q, pend_d;
    request_t                   req_in, req_eff;
    pattern_t                   pattern_q, pattern_d;
    logic [AUTO_W-1:0]          auto_cnt_q, auto_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       frame_pulse_q;
    logic                       load_err_q;

    vga_frame_edge_detect u_edge (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_VSync    (bus.i_VSync),
        .o_Boundary (boundary)
    );

    assign load_ok = pattern_in_range(bus.i_Load_Pattern, FIRST_C, LAST_C);

    // A load, valid or not, claims the cycle; a rejected load captures nothing.
    always_comb begin
        // NOTE: every combinationally driven variable gets a default first, so no latch is inferred.
        req_in.kind = REQ_NONE;
        req_in.code = '0;
        if (bus.i_Load) begin
            if (load_ok) begin
                req_in.kind = REQ_LOAD;
                req_in.code = bus.i_Load_Pattern;
            end
        end else if (bus.i_Next) begin
            req_in.kind = REQ_NEXT;
        end else if (bus.i_Prev) begin
            req_in.kind = REQ_PREV;
        end
    end

    // A request arriving in the boundary cycle itself bypasses the pending slot.
    assign req_eff = (req_in.kind != REQ_NONE) ? req_in : pend_q;

    always_comb begin
        state_d = bus.i_Auto_En ? AUTO : IDLE;
    end

    always_comb begin
        pattern_d   = pattern_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        auto_cnt_d  = (state_q == AUTO) ? auto_cnt_q : '0;

        if (boundary) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
            pend_d.kind = REQ_NONE;
            pend_d.code = '0;
            case (req_eff.kind)
                REQ_LOAD: begin
                    pattern_d  = req_eff.code;
                    auto_cnt_d = '0;
                end
                REQ_NEXT: begin
                    pattern_d  = pattern_next(pattern_q, FIRST_C, LAST_C);
                    auto_cnt_d = '0;
                end
                REQ_PREV: begin
                    pattern_d  = pattern_prev(pattern_q, FIRST_C, LAST_C);
                    auto_cnt_d = '0;
                end
                default: begin
                    if (state_q == AUTO) begin
                        if (auto_cnt_q == AUTO_LAST) begin
                            pattern_d  = pattern_next(pattern_q, FIRST_C, LAST_C);
                            auto_cnt_d = '0;
                        end else begin
                            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                        end
                    end
                end
            endcase
        end else if (req_in.kind != REQ_NONE) begin
            pend_d = req_in;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= IDLE;
            pend_q        <= '{kind: REQ_NONE, code: '0};
            pattern_q     <= RESET_C;
            auto_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            frame_pulse_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pattern_q     <= pattern_d;
            auto_cnt_q    <= auto_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_pulse_q <= boundary;
            load_err_q    <= bus.i_Load & ~load_ok;
        end
    end

    assign bus.o_Pattern     = pattern_q;
    assign bus.o_Frame_Pulse = frame_pulse_q;
    assign bus.o_Frame_Count = frame_cnt_q;
    assign bus.o_Load_Err    = load_err_q;
    assign bus.o_Pending     = (pend_q.kind != REQ_NONE);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: 60-clock frames (VSync high 40, low 20), every
// cycle compared to a frame-level reference model, plus directed tables/sequences.
module tb_vga_pattern_sequencer;

    localparam int FIRST   = 0;
    localparam int LAST    = 7;
    localparam int RST_PAT = 5;
    localparam int FPP     = 2;
    localparam int FCW     = 8;
    localparam int NPAT    = LAST - FIRST + 1;
    localparam int FRAME   = 60;
    localparam int ACTIVE  = 40;

    logic clk;
    logic rst_n;
    bit   auto_en;
    int   pos;
    int   checks;
    int   errors;
    int   pulses_seen;

    // Reference model state: a pattern index, the pending request and frames since last change.
    int m_pat, m_pend, m_pend_code, m_fcnt, m_frames;
    bit m_vs, m_auto, m_pulse, m_err;

    typedef struct {
        bit         nx;
        bit         pv;
        bit         ld;
        logic [3:0] code;
        int         at_pos;
        int         exp_pat;
        bit         exp_err;
        bit         exp_pend;
    } vec_t;

    vec_t vecs[14];
    int   auto_exp[8] = '{5, 5, 6, 6, 7, 7, 0, 0};

    vga_pattern_sequencer_if #(.FRAME_CNT_WIDTH(FCW)) bus ();

    vga_pattern_sequencer #(
        .PATTERN_FIRST      (FIRST),
        .PATTERN_LAST       (LAST),
        .RESET_PATTERN      (RST_PAT),
        .FRAMES_PER_PATTERN (FPP),
        .FRAME_CNT_WIDTH    (FCW)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic int model_next(int p);
        return FIRST + ((p - FIRST + 1) % NPAT);
    endfunction

    function automatic int model_prev(int p);
        return FIRST + ((p - FIRST + NPAT - 1) % NPAT);
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = RST_PAT; m_pend = 0; m_pend_code = 0; m_fcnt = 0; m_frames = 0;
        m_vs = 0; m_auto = 0; m_pulse = 0; m_err = 0;
    endtask

    // req/pend encoding in the model: 0 none, 1 next, 2 prev, 3 load.
    task automatic model_step(input bit vs, input bit ae, input bit nx, input bit pv,
                              input bit ld, input int code);
        int req, rcode, eff, ecode;
        bit b;
        req = 0; rcode = 0;
        b = m_vs && !vs;
        m_err = 0;
        if (ld) begin
            if (code >= FIRST && code <= LAST) begin req = 3; rcode = code; end
            else m_err = 1;
        end else if (nx) req = 1;
        else if (pv) req = 2;
        eff   = (req != 0) ? req : m_pend;
        ecode = (req != 0) ? rcode : m_pend_code;
        m_pulse = b;
        if (b) begin
            m_fcnt = (m_fcnt + 1) % (1 << FCW);
            m_pend = 0;
            if (eff == 3) begin m_pat = ecode; m_frames = 0; end
            else if (eff == 1) begin m_pat = model_next(m_pat); m_frames = 0; end
            else if (eff == 2) begin m_pat = model_prev(m_pat); m_frames = 0; end
            else if (m_auto) begin
                m_frames++;
                if (m_frames == FPP) begin m_pat = model_next(m_pat); m_frames = 0; end
            end
        end else if (req != 0) begin
            m_pend = req; m_pend_code = rcode;
        end
        if (!m_auto) m_frames = 0;
        m_auto = ae;
        m_vs   = vs;
    endtask

    task automatic tick(input bit nx, input bit pv, input bit ld, input logic [3:0] code);
        bit vs;
        vs = (pos < ACTIVE);
        bus.i_VSync        = vs;
        bus.i_Auto_En      = auto_en;
        bus.i_Next         = nx;
        bus.i_Prev         = pv;
        bus.i_Load         = ld;
        bus.i_Load_Pattern = code;
        if (rst_n) model_step(vs, auto_en, nx, pv, ld, int'(code));
        else       model_reset();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
        if (bus.o_Frame_Pulse === 1'b1) pulses_seen++;
        check("pattern",     bus.o_Pattern,     m_pat);
        check("frame_pulse", bus.o_Frame_Pulse, m_pulse);
        check("frame_count", bus.o_Frame_Count, m_fcnt);
        check("load_err",    bus.o_Load_Err,    m_err);
        check("pending",     bus.o_Pending,     m_pend != 0);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    task automatic run_until_pos(input int p);
        for (int i = 0; i < FRAME && pos != p; i++) idle();
    endtask

    task automatic do_reset(input bit restart_frame);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pattern",     bus.o_Pattern,     RST_PAT);
        check("rst_pending",     bus.o_Pending,     0);
        check("rst_frame_count", bus.o_Frame_Count, 0);
        check("rst_frame_pulse", bus.o_Frame_Pulse, 0);
        check("rst_load_err",    bus.o_Load_Err,    0);
        repeat (3) idle();
        rst_n = 1'b1;
        if (restart_frame) pos = 0;
    endtask

    initial begin
        bit nx, pv, ld;
        logic [3:0] code;

        checks = 0; errors = 0; pulses_seen = 0; pos = 0;
        rst_n = 1'b1; auto_en = 1'b0;
        bus.i_VSync = 1'b0; bus.i_Auto_En = 1'b0; bus.i_Next = 1'b0;
        bus.i_Prev = 1'b0; bus.i_Load = 1'b0; bus.i_Load_Pattern = 4'd0;
        model_reset();

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  10, 6, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 5, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd3,  10, 3, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 2, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 7, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  10, 0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd9,  12, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  40, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd7,  40, 7, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd15, 12, 7, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'd2,  30, 2, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd0,  40, 1, 1'b0, 1'b0};

        #5;

        // Reset and hold with auto off for five frames.
        auto_en = 1'b0;
        do_reset(1'b1);
        pulses_seen = 0;
        run_until_pos(ACTIVE);
        check("hold_pulse_before_fall", bus.o_Frame_Pulse, 0);
        idle();
        check("hold_pulse_after_fall", bus.o_Frame_Pulse, 1);
        idle();
        check("hold_pulse_one_cycle", bus.o_Frame_Pulse, 0);
        run_until_pos(0);
        repeat (4) run_cycles(FRAME);
        check("hold_pattern",     bus.o_Pattern,     RST_PAT);
        check("hold_frame_count", bus.o_Frame_Count, 5);
        check("hold_pulse_total", pulses_seen,       5);

        // Auto cycling from reset, sampled mid-frame.
        auto_en = 1'b1;
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) run_until_pos(21);
            else        run_cycles(FRAME);
            check($sformatf("auto_frame%0d", k), bus.o_Pattern, auto_exp[k]);
        end
        run_until_pos(45);
        check("auto_b8", bus.o_Pattern, 1);
        tick(1'b0, 1'b1, 1'b0, 4'd0);
        run_until_pos(50);
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        check("auto_latest_pending", bus.o_Pending, 1);
        run_until_pos(45);
        check("auto_latest_wins", bus.o_Pattern, 2);
        run_cycles(FRAME);
        check("auto_counter_restart", bus.o_Pattern, 2);
        run_cycles(FRAME);
        check("auto_resume", bus.o_Pattern, 3);

        // Manual request table with auto off.
        auto_en = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            run_until_pos(vecs[i].at_pos);
            tick(vecs[i].nx, vecs[i].pv, vecs[i].ld, vecs[i].code);
            check($sformatf("vec%0d_load_err", i), bus.o_Load_Err, vecs[i].exp_err);
            check($sformatf("vec%0d_pending", i),  bus.o_Pending,  vecs[i].exp_pend);
            run_until_pos(ACTIVE + 1);
            check($sformatf("vec%0d_pattern", i),  bus.o_Pattern,  vecs[i].exp_pat);
        end

        // Bad load keeps an earlier pending NEXT.
        run_until_pos(5);
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        run_until_pos(8);
        tick(1'b0, 1'b0, 1'b1, 4'd9);
        check("badload_err",          bus.o_Load_Err, 1);
        check("badload_keeps_pend",   bus.o_Pending,  1);
        run_until_pos(ACTIVE + 1);
        check("badload_next_applied", bus.o_Pattern,  2);

        // Reset mid-frame with a NEXT pending.
        run_until_pos(10);
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        run_until_pos(20);
        check("midrst_pending_before", bus.o_Pending, 1);
        do_reset(1'b0);
        run_until_pos(ACTIVE + 1);
        check("midrst_pattern",     bus.o_Pattern,     RST_PAT);
        check("midrst_frame_count", bus.o_Frame_Count, 1);
        check("midrst_pending",     bus.o_Pending,     0);

        // Random traffic against the model.
        auto_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            nx   = ($urandom_range(0, 99) < 4);
            pv   = ($urandom_range(0, 99) < 4);
            ld   = ($urandom_range(0, 99) < 4);
            code = 4'($urandom_range(0, 15));
            tick(nx, pv, ld, code);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Control block that selects which pattern the test-pattern generator drives. It feeds the 4-bit pattern-select input of the generator and watches the VSync from the sync-pulse generator. Pattern changes come from auto-cycling, manual next/prev pulses or a direct load, and are applied only at a frame boundary (start of vertical blanking) so no frame is ever torn. It also exports frame timing for other consumers.

Parameters:
PATTERN_FIRST, 0, lowest legal pattern code (inclusive).
PATTERN_LAST, 7, highest legal pattern code (inclusive); PATTERN_FIRST <= PATTERN_LAST <= 15.
RESET_PATTERN, 5, pattern driven out of reset (color bars); must lie in [FIRST, LAST].
FRAMES_PER_PATTERN, 60, frame boundaries per auto step; >= 1.
FRAME_CNT_WIDTH, 8, width of the frame counter and o_Frame_Count.

Ports:
i_Clk  in  1  pixel clock, same clock as the sync/pattern pipeline.
i_Rst_L  in  1  asynchronous active-low reset.
i_VSync  in  1  VSync from the sync-pulse generator; high during active rows, low during vertical blanking.
i_Auto_En  in  1  level; 1 = auto-cycle through patterns.
i_Next  in  1  single-cycle pulse; request the next pattern.
i_Prev  in  1  single-cycle pulse; request the previous pattern.
i_Load  in  1  single-cycle pulse; request a jump to i_Load_Pattern.
i_Load_Pattern  in  4  target code, sampled in the same cycle as i_Load.
o_Pattern  out  4  pattern select to the generator.
o_Frame_Pulse  out  1  1-cycle pulse on each frame boundary.
o_Frame_Count  out  FRAME_CNT_WIDTH  free-running boundary count; wraps to 0.
o_Load_Err  out  1  1-cycle pulse when an i_Load code is out of range.
o_Pending  out  1  1 while a manual request waits for a boundary.

Behaviour:
- Reset (asynchronous, while i_Rst_L=0):
  - o_Pattern=RESET_PATTERN.
  - o_Frame_Pulse=0, o_Frame_Count=0, o_Load_Err=0, o_Pending=0.
  - Auto counter=0, pending request=NONE, registered VSync r_VSync=0.
- Reset asserted mid-frame clears any pending request. Because r_VSync resets to 0, no boundary is seen until VSync has been observed high, so no false edge occurs after reset.
- Boundary detection:
  - r_VSync <= i_VSync every cycle.
  - Boundary B is true in the cycle where r_VSync=1 and i_VSync=0 (VSync falling edge).
  - o_Frame_Pulse and o_Pattern update on the clock edge that ends cycle B, i.e. 1 cycle after i_VSync falls.
  - o_Frame_Count increments at every B, including when nothing changes.
- Request capture (any cycle, registered):
  - Priority within one cycle: i_Load > i_Next > i_Prev.
  - The latest accepted request overwrites any earlier pending one.
  - i_Load with code outside [FIRST, LAST] is dropped, o_Load_Err pulses the next cycle, and any existing pending request is kept.
  - o_Pending=1 from the cycle after capture until the B edge that applies the request.
- A request arriving in cycle B itself is applied at that same boundary; this equals a capture-and-apply bypass.
- State machine, states IDLE/AUTO:
  - IDLE when i_Auto_En=0; AUTO when i_Auto_En=1. The state follows i_Auto_En with 1 cycle of registration.
  - IDLE -> AUTO clears the auto counter.
  - In IDLE the auto counter holds at 0.
- Action at B, first match wins:
  1. Pending LOAD: o_Pattern=load code; auto counter=0.
  2. Pending NEXT: o_Pattern+1, wrapping LAST->FIRST; auto counter=0.
  3. Pending PREV: o_Pattern-1, wrapping FIRST->LAST; auto counter=0.
  4. AUTO and auto counter==FRAMES_PER_PATTERN-1: advance as NEXT; auto counter=0.
  5. AUTO otherwise: auto counter+1.
  6. IDLE: no change.
- If PATTERN_FIRST==PATTERN_LAST, next/prev/auto leave o_Pattern unchanged.
- o_Pattern never changes outside a B edge (except reset). Arithmetic is 4-bit with explicit wrap compares; there is no modulo.
- The auto counter width is clog2(FRAMES_PER_PATTERN), with a minimum of 1.

Decomposition:
- Shared package vga_ctrl_pkg:
  - PATTERN_WIDTH=4.
  - Named pattern codes, e.g. PAT_BLACK=0, PAT_COLOR_BARS=5.
  - Request encoding REQ_NONE/REQ_NEXT/REQ_PREV/REQ_LOAD.
  - State encoding IDLE/AUTO.
- One sub-module, vga_frame_edge_detect: registers i_VSync and emits the B strobe. It is reusable by other frame-synchronous controllers.

Test Plan:
Bench setup: 10x6 timing with 8x4 active (VSync high 40 clocks, low 20, frame = 60 clocks, 40 ns clock). Overrides: FRAMES_PER_PATTERN=2, PATTERN_FIRST=0, PATTERN_LAST=7, RESET_PATTERN=5.
1. Reset and hold: i_Auto_En=0 for 5 frames -> o_Pattern stays 5; o_Frame_Count reaches 5; o_Frame_Pulse fires exactly 1 cycle after each VSync fall.
2. Auto wrap: i_Auto_En=1 from reset -> o_Pattern goes 5,5,6,6,7,7,0,0 across boundaries. The change lands exactly 1 cycle after VSync falls; mid-frame values are stable.
3. Manual priority and latest-wins:
   - In auto, pulse i_Prev, then i_Next in the same frame -> at the next B, o_Pattern=current+1; the auto counter restarts.
   - i_Next with i_Load=3 in the same cycle -> o_Pattern=3.
4. Wrap and load error:
   - From 0, i_Prev -> 7.
   - i_Load with code 9 -> o_Load_Err pulses 1 cycle; o_Pattern is unchanged; an earlier pending NEXT is still applied.
5. Boundary coincidence: i_Next asserted in cycle B -> applied at that same boundary; o_Pending never rises.
6. Reset mid-frame with a NEXT pending: i_Rst_L=0 for 3 cycles, then 1 -> o_Pattern=5, o_Pending=0, o_Frame_Count=0. There is no pattern change at the first boundary unless a new request arrives.
